// File: rtl/cpu_mux_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mux_pkg
// Shared definitions for the CPU datapath selectors: default widths and the
// named select encodings used at each mux site.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_mux_pkg;

  // Default widths for register-address and data-path selectors.
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Destination / operand register select encodings.
  typedef enum logic [1:0] {
    SEL_RT = 2'd0,
    SEL_RD = 2'd1,
    SEL_RA = 2'd2
  } reg_sel_e;

  // Forwarding select encodings for ALU operands.
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_WB   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/reg_mux_n_if.sv
// ---------------------------------------------------------------------------
// reg_mux_n_if
// Bundles the input-side and output-side valid/ready handshakes of reg_mux_n.
// Parameters: WIDTH (data width), NUM_IN (number of data inputs).
// Signals:
//   in_valid/in_ready/sel/in_data   upstream select+data transfer
//   out_valid/out_ready/out_data    downstream result transfer
//   sel_err                         sticky out-of-range select flag
// Modports:
//   master - the environment (drives inputs, observes outputs)
//   slave  - the reg_mux_n block
// ---------------------------------------------------------------------------
interface reg_mux_n_if
  import cpu_mux_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NUM_IN = 4
);

  localparam int SEL_W = $clog2(NUM_IN);

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    sel_err;

  modport master (
    output in_valid, sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );

  modport slave (
    input  in_valid, sel, in_data, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );

endinterface

// File: rtl/reg_mux_n_comb.sv
// ---------------------------------------------------------------------------
// mux_n_comb
// Purely combinational N:1 selector. Input k is in_data[k*WIDTH +: WIDTH].
// An index with no matching input (sel >= NUM_IN) yields all zeros.
// Ports:
//   sel      in   SEL_W         input index
//   in_data  in   NUM_IN*WIDTH  packed inputs
//   out_data out  WIDTH         selected input (or zero)
// ---------------------------------------------------------------------------
module mux_n_comb #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic [$clog2(NUM_IN)-1:0] sel,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  output logic [WIDTH-1:0]          out_data
);

  localparam int SEL_W = $clog2(NUM_IN);

  // Compare against every legal index; no match leaves the zero default,
  // which is what makes out-of-range selects forward zeros.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == k[SEL_W-1:0]) begin
        out_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/reg_mux_n.sv
// ---------------------------------------------------------------------------
// reg_mux_n
// Registered N:1 data selector with valid/ready handshakes on both sides.
// The select is resolved when a beat is accepted; the chosen word is held in
// a main register, with a one-entry skid register so that in_ready can come
// straight from a flop while still sustaining one transfer per cycle.
// Parameters: WIDTH (default 32), NUM_IN (default 4, legal 2..16).
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   bus   reg_mux_n_if.slave (in_valid/in_ready/sel/in_data,
//         out_valid/out_ready/out_data, sel_err)
// Optional feature macro: REG_MUX_SEL_CHECK_EN - when defined, an accepted
// out-of-range select sets a sticky sel_err; otherwise sel_err is tied low.
// ---------------------------------------------------------------------------
module reg_mux_n
  import cpu_mux_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NUM_IN = 4
) (
  input logic        clk,
  input logic        rst,
  reg_mux_n_if.slave bus
);

  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             emit;

  // Single selector at the input; both storage registers load from it.
  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .sel      (bus.sel),
    .in_data  (bus.in_data),
    .out_data (sel_data)
  );

  // in_ready is the inverse of the skid flop, so out_ready never reaches it
  // combinationally.
  assign accept        = bus.in_valid && !skid_v;
  assign emit          = main_v && bus.out_ready;
  assign bus.in_ready  = !skid_v;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_d;

  // Main/skid storage. An emit either refills main from the skid, replaces it
  // with a same-cycle accept, or empties it. Without an emit, an accept goes
  // to main if it is empty and to the skid otherwise. Accept can never
  // coincide with a full skid because in_ready is low then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (emit) begin
      if (skid_v) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end else if (accept) begin
        main_d <= sel_data;
      end else begin
        main_v <= 1'b0;
      end
    end else if (accept) begin
      if (!main_v) begin
        main_d <= sel_data;
        main_v <= 1'b1;
      end else begin
        skid_d <= sel_data;
        skid_v <= 1'b1;
      end
    end
  end

`ifdef REG_MUX_SEL_CHECK_EN
  localparam int SEL_W = $clog2(NUM_IN);

  logic sel_legal;
  logic sel_err_q;

  // A select is legal only if it names one of the NUM_IN inputs; this stays
  // free of constant compares when NUM_IN is a power of two.
  always_comb begin
    sel_legal = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == k[SEL_W-1:0]) begin
        sel_legal = 1'b1;
      end
    end
  end

  // Sticky error: set by any accepted illegal select, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (accept && !sel_legal) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_mux_n.sv
// ---------------------------------------------------------------------------
// tb_reg_mux_n
// Self-checking bench for reg_mux_n. Three instances: 32-bit/4-input (main,
// checked every cycle against a queue model), 5-bit/2-input (register-address
// use), 8-bit/3-input (out-of-range select).
// ---------------------------------------------------------------------------
module tb_reg_mux_n;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

`ifdef REG_MUX_SEL_CHECK_EN
  localparam logic SEL_ERR_EXP = 1'b1;
`else
  localparam logic SEL_ERR_EXP = 1'b0;
`endif

  reg_mux_n_if #(.WIDTH(32), .NUM_IN(4)) if4 ();
  reg_mux_n_if #(.WIDTH(5),  .NUM_IN(2)) if2 ();
  reg_mux_n_if #(.WIDTH(8),  .NUM_IN(3)) if3 ();

  reg_mux_n #(.WIDTH(32), .NUM_IN(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  reg_mux_n #(.WIDTH(5),  .NUM_IN(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  reg_mux_n #(.WIDTH(8),  .NUM_IN(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  always #5 clk = ~clk;

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive the main instance's inputs for the next clock edge.
  task automatic applyStimulus(input logic v, input logic [1:0] s,
                               input logic [127:0] d, input logic r);
    @(posedge clk);
    #1;
    if4.in_valid  = v;
    if4.sel       = s;
    if4.in_data   = d;
    if4.out_ready = r;
  endtask

  // Word s of the packed 4x32 input vector.
  function automatic logic [31:0] modelSel(input logic [1:0] s, input logic [127:0] d);
    logic [127:0] sh;
    sh = d >> (32 * int'(s));
    return sh[31:0];
  endfunction

  // Model of the main instance: the contents in flight, in order.
  logic [31:0] exp_q[$];
  int emit_cnt = 0;

  always @(posedge rst) exp_q.delete();

  // Mid-cycle compare: outputs follow from the queue occupancy (one main
  // slot plus one skid slot), then this cycle's transfers update the queue.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("out_valid", {63'd0, if4.out_valid}, {63'd0, exp_q.size() > 0});
      checkOutput("in_ready", {63'd0, if4.in_ready}, {63'd0, exp_q.size() < 2});
      if (if4.out_valid && exp_q.size() > 0)
        checkOutput("out_data", {32'd0, if4.out_data}, {32'd0, exp_q[0]});
      if (if4.out_valid && if4.out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        emit_cnt++;
      end
      if (if4.in_valid && if4.in_ready)
        exp_q.push_back(modelSel(if4.sel, if4.in_data));
    end
  end

  localparam logic [127:0] D4 = {32'h44, 32'h33, 32'h22, 32'h11};

  initial begin
    int start_cnt;
    logic ir;
    clk = 1'b0;
    rst = 1'b1;
    if4.in_valid = 1'b0; if4.sel = '0; if4.in_data = '0; if4.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.sel = '0; if2.in_data = '0; if2.out_ready = 1'b0;
    if3.in_valid = 1'b0; if3.sel = '0; if3.in_data = '0; if3.out_ready = 1'b0;

    // Reset state.
    #2;
    checkOutput("rst_in_ready", {63'd0, if4.in_ready}, 64'd1);
    checkOutput("rst_out_valid", {63'd0, if4.out_valid}, 64'd0);
    checkOutput("rst_out_data", {32'd0, if4.out_data}, 64'd0);
    checkOutput("rst_sel_err", {63'd0, if4.sel_err}, 64'd0);
    checkOutput("rst_in_ready2", {63'd0, if2.in_ready}, 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 2:1 register-address select.
    $display("[TB] basic 5-bit 2:1 select");
    @(posedge clk); #1;
    if2.in_data = {5'h15, 5'h0A}; if2.sel = 1'b1; if2.in_valid = 1'b1; if2.out_ready = 1'b1;
    @(posedge clk); #1;
    if2.sel = 1'b0;
    checkOutput("basic_valid1", {63'd0, if2.out_valid}, 64'd1);
    checkOutput("basic_sel1", {59'd0, if2.out_data}, 64'h15);
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
    checkOutput("basic_sel0", {59'd0, if2.out_data}, 64'h0A);
    @(posedge clk); #1;
    checkOutput("basic_drained", {63'd0, if2.out_valid}, 64'd0);
    checkOutput("basic_data_kept", {59'd0, if2.out_data}, 64'h0A);

    // Backpressure: main holds 0x11, skid 0x22, third beat stalls.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 2'd0, D4, 1'b0);
    applyStimulus(1'b1, 2'd1, D4, 1'b0);
    applyStimulus(1'b1, 2'd2, D4, 1'b0);
    applyStimulus(1'b1, 2'd2, D4, 1'b0);
    checkOutput("bp_main", {32'd0, if4.out_data}, 64'h11);
    checkOutput("bp_in_ready", {63'd0, if4.in_ready}, 64'd0);
    if4.out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_comb", {63'd0, if4.in_ready}, 64'd0);
    applyStimulus(1'b1, 2'd2, D4, 1'b1);
    checkOutput("bp_second", {32'd0, if4.out_data}, 64'h22);
    checkOutput("bp_in_ready_up", {63'd0, if4.in_ready}, 64'd1);
    applyStimulus(1'b0, 2'd0, D4, 1'b1);
    checkOutput("bp_third", {32'd0, if4.out_data}, 64'h33);
    applyStimulus(1'b0, 2'd0, D4, 1'b1);
    checkOutput("bp_empty", {63'd0, if4.out_valid}, 64'd0);

    // Throughput: 100 beats must all leave within 101 cycles.
    $display("[TB] throughput");
    start_cnt = emit_cnt;
    for (int i = 0; i < 100; i++)
      applyStimulus(1'b1, 2'($urandom_range(0, 3)),
                    {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    applyStimulus(1'b0, 2'd0, D4, 1'b1);
    @(posedge clk); #1;
    checkOutput("tput_count", 64'(emit_cnt - start_cnt), 64'd100);
    checkOutput("tput_empty", {63'd0, if4.out_valid}, 64'd0);

    // Random stalls on both sides.
    $display("[TB] random stalls");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      if (i % 500 == 0) begin
        ir = if4.in_ready;
        if4.out_ready = ~if4.out_ready;
        #1;
        checkOutput("rand_in_ready_comb", {63'd0, if4.in_ready}, {63'd0, ir});
      end
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, D4, 1'b1);
    checkOutput("rand_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with main and skid both full.
    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 2'd0, D4, 1'b0);
    applyStimulus(1'b1, 2'd1, D4, 1'b0);
    applyStimulus(1'b0, 2'd0, D4, 1'b0);
    checkOutput("rstmid_full", {63'd0, if4.in_ready}, 64'd0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_valid", {63'd0, if4.out_valid}, 64'd0);
    checkOutput("rstmid_ready", {63'd0, if4.in_ready}, 64'd1);
    checkOutput("rstmid_data", {32'd0, if4.out_data}, 64'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 2'd3, D4, 1'b1);
    applyStimulus(1'b0, 2'd0, D4, 1'b1);
    checkOutput("rstmid_next", {32'd0, if4.out_data}, 64'h44);
    applyStimulus(1'b0, 2'd0, D4, 1'b1);
    checkOutput("rstmid_next_gone", {63'd0, if4.out_valid}, 64'd0);

    // Out-of-range select on the 3-input instance.
    $display("[TB] range check");
    @(posedge clk); #1;
    checkOutput("range_err_init", {63'd0, if3.sel_err}, 64'd0);
    if3.in_data = {8'h33, 8'h22, 8'h11}; if3.out_ready = 1'b1;
    if3.in_valid = 1'b1; if3.sel = 2'd1;
    @(posedge clk); #1;
    if3.sel = 2'd3;
    checkOutput("range_legal", {56'd0, if3.out_data}, 64'h22);
    checkOutput("range_err_legal", {63'd0, if3.sel_err}, 64'd0);
    @(posedge clk); #1;
    if3.sel = 2'd2;
    checkOutput("range_zero_valid", {63'd0, if3.out_valid}, 64'd1);
    checkOutput("range_zero", {56'd0, if3.out_data}, 64'd0);
    checkOutput("range_err", {63'd0, if3.sel_err}, {63'd0, SEL_ERR_EXP});
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
    checkOutput("range_after", {56'd0, if3.out_data}, 64'h33);
    checkOutput("range_err_sticky", {63'd0, if3.sel_err}, {63'd0, SEL_ERR_EXP});
    @(posedge clk); #1;
    checkOutput("range_err_sticky2", {63'd0, if3.sel_err}, {63'd0, SEL_ERR_EXP});
    rst = 1'b1;
    #1;
    checkOutput("range_err_cleared", {63'd0, if3.sel_err}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
